text_display_controller: RTL and testbench

Sequences the 8x16 font ROM for 80x30 text-mode video. Per active pixel it fetches the character code from the shared text RAM, drives the font ROM's character and cell coordinates, and returns a pipelined monochrome pixel with a blinking underline cursor. It also arbitrates the single text-RAM port between the display (priority) and CPU writes (valid/ready). It sits between the VGA timing generator, the text RAM, the font ROM and the CPU bus bridge in the GPU.

---
 rtl/text_display_controller_if.sv | 61 ++++++
 rtl/text_display_controller.sv | 187 ++++++++++++++++++
 tb/tb_text_display_controller.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_display_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : text_display_controller_if
// Brief   : Bundle of the timing, CPU write, text RAM, font ROM and video
//           output signals of the text display controller.
// Revision: 1.0 - initial release
// ============================================================================
interface text_display_controller_if;
    // Timing generator side
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        active_in;
    logic        hsync_in;
    logic        vsync_in;
    // CPU write port
    logic        cpu_wr_valid;
    logic        cpu_wr_ready;
    logic [11:0] cpu_wr_addr;
    logic [6:0]  cpu_wr_data;
    // Cursor control
    logic        cursor_en;
    logic [11:0] cursor_addr;
    // Text RAM port
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [6:0]  ram_wdata;
    logic [6:0]  ram_rdata;
    // Font ROM port
    logic [6:0]  font_character;
    logic [2:0]  font_cell_x;
    logic [3:0]  font_cell_y;
    logic        font_pixel_value;
    // Video output
    logic        pixel_out;
    logic        active_out;
    logic        hsync_out;
    logic        vsync_out;

    // Environment view: timing generator, CPU bridge, RAM and ROM
    modport master (
        output pixel_x, pixel_y, active_in, hsync_in, vsync_in,
        output cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        output cursor_en, cursor_addr,
        output ram_rdata, font_pixel_value,
        input  cpu_wr_ready, ram_addr, ram_we, ram_wdata,
        input  font_character, font_cell_x, font_cell_y,
        input  pixel_out, active_out, hsync_out, vsync_out
    );

    // Controller view
    modport slave (
        input  pixel_x, pixel_y, active_in, hsync_in, vsync_in,
        input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        input  cursor_en, cursor_addr,
        input  ram_rdata, font_pixel_value,
        output cpu_wr_ready, ram_addr, ram_we, ram_wdata,
        output font_character, font_cell_x, font_cell_y,
        output pixel_out, active_out, hsync_out, vsync_out
    );
endinterface
`default_nettype wire

// File: rtl/text_display_controller.sv
`default_nettype none
// ============================================================================
// Module  : text_display_controller
// Brief   : 80x30 text-mode pixel pipeline. Fetches character codes from the
//           shared text RAM, addresses the 8x16 font ROM, overlays a blinking
//           underline cursor and arbitrates CPU writes into the text RAM
//           (display has priority).
// Revision: 1.0 - initial release
// ============================================================================
module text_display_controller #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  wire logic              CLOCK_150,
    input  wire logic              RESET,
    text_display_controller_if.slave bus
);

    localparam logic [12:0] c_COLS13  = 13'(COLS);
    localparam logic [12:0] c_ROWS13  = 13'(ROWS);
    localparam logic [12:0] c_CELLS13 = 13'(COLS * ROWS);
    localparam int          c_CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BLINK_FRAMES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Character cell coordinates of the current pixel
    logic [5:0]  w_row;
    logic [6:0]  w_col;
    logic [12:0] w_disp_addr_full;
    logic [11:0] w_disp_addr;
    logic        w_blank;
    logic        w_match;
    logic        w_cpu_in_range;
    logic        w_invert;

    // Stage 1: RAM port and sampled pixel attributes
    logic [11:0] r_ram_addr;
    logic        r_ram_we;
    logic [6:0]  r_ram_wdata;
    logic        r_s1_active, r_s1_blank, r_s1_match, r_s1_hs, r_s1_vs;
    logic [2:0]  r_s1_cx;
    logic [3:0]  r_s1_cy;
    // Stage 2: cell coordinates presented alongside ram_rdata
    logic [2:0]  r_cell_x;
    logic [3:0]  r_cell_y;
    logic        r_s2_active, r_s2_blank, r_s2_match, r_s2_hs, r_s2_vs;
    // Stage 3: aligned with font_pixel_value
    logic        r_s3_active, r_s3_blank, r_s3_match, r_s3_ul, r_s3_hs, r_s3_vs;
    // Stage 4: video outputs
    logic        r_pixel, r_active_out, r_hs_out, r_vs_out;
    // Cursor blink timing
    logic                r_vs_prev;
    logic [c_CNT_W-1:0]  r_frame_cnt;
    logic                r_blink;

    assign w_row            = bus.pixel_y[9:4];
    assign w_col            = bus.pixel_x[9:3];
    // Worst case 63*80+127 still fits in 13 bits, so no overflow before truncation
    assign w_disp_addr_full = ({7'b0, w_row} * c_COLS13) + {6'b0, w_col};
    assign w_disp_addr      = w_disp_addr_full[11:0];
    assign w_blank          = ({7'b0, w_row} >= c_ROWS13) || ({6'b0, w_col} >= c_COLS13);
    assign w_match          = bus.cursor_en && (w_disp_addr == bus.cursor_addr);
    assign w_cpu_in_range   = ({1'b0, bus.cpu_wr_addr} < c_CELLS13);
    assign w_invert         = r_s3_match & r_blink & r_s3_ul;

    // The display owns the RAM port whenever it is fetching; reset also blocks writes
    assign bus.cpu_wr_ready   = ~bus.active_in & ~RESET;
    assign bus.ram_addr       = r_ram_addr;
    assign bus.ram_we         = r_ram_we;
    assign bus.ram_wdata      = r_ram_wdata;
    assign bus.font_character = bus.ram_rdata;
    assign bus.font_cell_x    = r_cell_x;
    assign bus.font_cell_y    = r_cell_y;
    assign bus.pixel_out      = r_pixel;
    assign bus.active_out     = r_active_out;
    assign bus.hsync_out      = r_hs_out;
    assign bus.vsync_out      = r_vs_out;

    // Stage 1: arbitrate the text RAM port and capture per-pixel attributes
    always_ff @(posedge CLOCK_150 or posedge RESET) begin
        if (RESET) begin
            r_ram_addr  <= 12'd0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= 7'd0;
            r_s1_active <= 1'b0;
            r_s1_blank  <= 1'b0;
            r_s1_match  <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_cx     <= 3'd0;
            r_s1_cy     <= 4'd0;
        end else begin
            if (bus.active_in) begin
                r_ram_addr <= w_disp_addr;
                r_ram_we   <= 1'b0;
            end else if (bus.cpu_wr_valid) begin
                // Out-of-range writes complete the handshake but never reach RAM
                if (w_cpu_in_range) begin
                    r_ram_addr  <= bus.cpu_wr_addr;
                    r_ram_wdata <= bus.cpu_wr_data;
                    r_ram_we    <= 1'b1;
                end else begin
                    r_ram_we    <= 1'b0;
                end
            end else begin
                r_ram_we <= 1'b0;
            end
            r_s1_active <= bus.active_in;
            r_s1_blank  <= w_blank;
            r_s1_match  <= w_match;
            r_s1_hs     <= bus.hsync_in;
            r_s1_vs     <= bus.vsync_in;
            r_s1_cx     <= bus.pixel_x[2:0];
            r_s1_cy     <= bus.pixel_y[3:0];
        end
    end

    // Stages 2 and 3: follow the RAM and font ROM read latencies
    always_ff @(posedge CLOCK_150 or posedge RESET) begin
        if (RESET) begin
            r_cell_x    <= 3'd0;
            r_cell_y    <= 4'd0;
            r_s2_active <= 1'b0;
            r_s2_blank  <= 1'b0;
            r_s2_match  <= 1'b0;
            r_s2_hs     <= 1'b0;
            r_s2_vs     <= 1'b0;
            r_s3_active <= 1'b0;
            r_s3_blank  <= 1'b0;
            r_s3_match  <= 1'b0;
            r_s3_ul     <= 1'b0;
            r_s3_hs     <= 1'b0;
            r_s3_vs     <= 1'b0;
        end else begin
            r_cell_x    <= r_s1_cx;
            r_cell_y    <= r_s1_cy;
            r_s2_active <= r_s1_active;
            r_s2_blank  <= r_s1_blank;
            r_s2_match  <= r_s1_match;
            r_s2_hs     <= r_s1_hs;
            r_s2_vs     <= r_s1_vs;
            r_s3_active <= r_s2_active;
            r_s3_blank  <= r_s2_blank;
            r_s3_match  <= r_s2_match;
            r_s3_ul     <= (r_cell_y >= 4'd14);
            r_s3_hs     <= r_s2_hs;
            r_s3_vs     <= r_s2_vs;
        end
    end

    // Stage 4: final pixel with cursor underline and aligned syncs
    always_ff @(posedge CLOCK_150 or posedge RESET) begin
        if (RESET) begin
            r_pixel      <= 1'b0;
            r_active_out <= 1'b0;
            r_hs_out     <= 1'b0;
            r_vs_out     <= 1'b0;
        end else begin
            r_pixel      <= r_s3_active & ~r_s3_blank & (bus.font_pixel_value ^ w_invert);
            r_active_out <= r_s3_active;
            r_hs_out     <= r_s3_hs;
            r_vs_out     <= r_s3_vs;
        end
    end

    // Count vsync rising edges and flip the blink phase once per BLINK_FRAMES
    always_ff @(posedge CLOCK_150 or posedge RESET) begin
        if (RESET) begin
            r_vs_prev   <= 1'b0;
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
        end else begin
            r_vs_prev <= bus.vsync_in;
            if (bus.vsync_in && !r_vs_prev) begin
                if (r_frame_cnt == c_CNT_LAST) begin
                    r_frame_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_display_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_text_display_controller
// Brief   : Directed, table-driven bench for text_display_controller with a
//           behavioural text RAM and font ROM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_text_display_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    logic font_mode = 1'b0;   // 0: pattern font, 1: solid-0 font
    logic [6:0] mem [0:4095];
    int total = 0;
    int bad   = 0;

    text_display_controller_if u_if ();

    text_display_controller #(
        .COLS(80), .ROWS(30), .BLINK_FRAMES(30)
    ) u_dut (
        .CLOCK_150 (clk),
        .RESET     (rst),
        .bus       (u_if)
    );

    always #5 clk = ~clk;

    // Text RAM model: one-cycle read latency, read-before-write
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= (i == 0) ? 7'h41 : i[6:0];
        end else begin
            if (u_if.ram_we) mem[u_if.ram_addr] <= u_if.ram_wdata;
            u_if.ram_rdata <= mem[u_if.ram_addr];
        end
    end

    // Font pattern: row byte = {0,char} ^ (cy<<1), bit index = cx
    function automatic logic fbit(input logic [6:0] ch, input logic [2:0] cx, input logic [3:0] cy);
        logic [7:0] b;
        b = {1'b0, ch} ^ {3'b0, cy, 1'b0};
        return b[cx];
    endfunction

    // Font ROM model: one-cycle latency
    always @(posedge clk) begin
        u_if.font_pixel_value <= font_mode ? 1'b0
                               : fbit(u_if.font_character, u_if.font_cell_x, u_if.font_cell_y);
    end

    typedef struct {
        logic [9:0]  px;
        logic [9:0]  py;
        logic [11:0] addr;
        logic [6:0]  ch;
        logic [2:0]  cx;
        logic [3:0]  cy;
        logic        pix;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single active pixel followed by blanking; checks every pipeline stage
    task automatic run_pixel(input string tag, input vec_t v);
        @(negedge clk);
        u_if.pixel_x   = v.px;
        u_if.pixel_y   = v.py;
        u_if.active_in = 1'b1;
        @(posedge clk); @(negedge clk);
        chk({tag, "_addr"}, 32'(u_if.ram_addr), 32'(v.addr));
        chk({tag, "_we"}, 32'(u_if.ram_we), 32'd0);
        u_if.active_in = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({tag, "_char"}, 32'(u_if.font_character), 32'(v.ch));
        chk({tag, "_cx"}, 32'(u_if.font_cell_x), 32'(v.cx));
        chk({tag, "_cy"}, 32'(u_if.font_cell_y), 32'(v.cy));
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk({tag, "_pix"}, 32'(u_if.pixel_out), 32'(v.pix));
        chk({tag, "_act"}, 32'(u_if.active_out), 32'd1);
    endtask

    // Cursor probe: only the final pixel matters
    task automatic cur_pixel(input string tag, input logic [9:0] px, input logic [9:0] py, input logic ep);
        @(negedge clk);
        u_if.pixel_x   = px;
        u_if.pixel_y   = py;
        u_if.active_in = 1'b1;
        @(negedge clk);
        u_if.active_in = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); @(negedge clk);
        chk(tag, 32'(u_if.pixel_out), 32'(ep));
    endtask

    task automatic vsync_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); u_if.vsync_in = 1'b1;
            @(negedge clk); u_if.vsync_in = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ph;
        logic [15:0] pv;
        vec_t v;

        vecs[0] = '{10'd3,   10'd5,   12'd0,    7'h41, 3'd3, 4'd5,  1'b1};
        vecs[1] = '{10'd639, 10'd479, 12'd2399, 7'h5F, 3'd7, 4'd15, 1'b0};
        vecs[2] = '{10'd8,   10'd16,  12'd81,   7'h51, 3'd0, 4'd0,  1'b1};
        vecs[3] = '{10'd17,  10'd33,  12'd162,  7'h22, 3'd1, 4'd1,  1'b0};
        vecs[4] = '{10'd100, 10'd200, 12'd972,  7'h4C, 3'd4, 4'd8,  1'b1};
        vecs[5] = '{10'd646, 10'd3,   12'd80,   7'h50, 3'd6, 4'd3,  1'b0};
        vecs[6] = '{10'd13,  10'd480, 12'd2401, 7'h61, 3'd5, 4'd0,  1'b0};
        vecs[7] = '{10'd2,   10'd18,  12'd80,   7'h50, 3'd2, 4'd2,  1'b1};

        u_if.pixel_x = '0; u_if.pixel_y = '0; u_if.active_in = 1'b0;
        u_if.hsync_in = 1'b0; u_if.vsync_in = 1'b0;
        u_if.cpu_wr_valid = 1'b0; u_if.cpu_wr_addr = '0; u_if.cpu_wr_data = '0;
        u_if.cursor_en = 1'b0; u_if.cursor_addr = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        u_if.cpu_wr_valid = 1'b1;
        #1;
        chk("rst_ready", 32'(u_if.cpu_wr_ready), 32'd0);
        chk("rst_addr", 32'(u_if.ram_addr), 32'd0);
        chk("rst_we", 32'(u_if.ram_we), 32'd0);
        chk("rst_wdata", 32'(u_if.ram_wdata), 32'd0);
        chk("rst_cell", 32'({u_if.font_cell_x, u_if.font_cell_y}), 32'd0);
        chk("rst_outs", 32'({u_if.pixel_out, u_if.active_out, u_if.hsync_out, u_if.vsync_out}), 32'd0);
        u_if.cpu_wr_valid = 1'b0;
        rst = 1'b0;
        #1;
        u_if.cpu_wr_valid = 1'b1;
        #1;
        chk("ready_idle", 32'(u_if.cpu_wr_ready), 32'd1);
        u_if.cpu_wr_valid = 1'b0;

        // Display pipeline vectors
        for (int i = 0; i < 8; i++) run_pixel($sformatf("vec%0d", i), vecs[i]);

        // Mid-frame reset with a write pending on the RAM port
        @(negedge clk); u_if.hsync_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("hs_before_rst", 32'(u_if.hsync_out), 32'd1);
        u_if.cpu_wr_valid = 1'b1; u_if.cpu_wr_addr = 12'd500; u_if.cpu_wr_data = 7'h7F;
        @(posedge clk); @(negedge clk);
        chk("pend_we", 32'(u_if.ram_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(u_if.ram_we), 32'd0);
        chk("mid_rst_addr", 32'(u_if.ram_addr), 32'd0);
        chk("mid_rst_ready", 32'(u_if.cpu_wr_ready), 32'd0);
        chk("mid_rst_hs", 32'(u_if.hsync_out), 32'd0);
        u_if.cpu_wr_valid = 1'b0; u_if.hsync_in = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("no_write_500", 32'(mem[500]), 32'h74);
        rst = 1'b0;
        run_pixel("post_rst", vecs[0]);

        // CPU write held off by active display
        @(negedge clk);
        u_if.pixel_x = 10'd0; u_if.pixel_y = 10'd0; u_if.active_in = 1'b1;
        u_if.cpu_wr_valid = 1'b1; u_if.cpu_wr_addr = 12'd81; u_if.cpu_wr_data = 7'h5A;
        #1;
        chk("wr_blocked_ready", 32'(u_if.cpu_wr_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            chk("wr_blocked_we", 32'(u_if.ram_we), 32'd0);
        end
        u_if.active_in = 1'b0;
        #1;
        chk("wr_ready", 32'(u_if.cpu_wr_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("wr_we", 32'(u_if.ram_we), 32'd1);
        chk("wr_addr", 32'(u_if.ram_addr), 32'd81);
        chk("wr_data", 32'(u_if.ram_wdata), 32'h5A);
        u_if.cpu_wr_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("wr_we_drop", 32'(u_if.ram_we), 32'd0);
        chk("wr_mem81", 32'(mem[81]), 32'h5A);

        // Out-of-range write is accepted but dropped
        u_if.cpu_wr_valid = 1'b1; u_if.cpu_wr_addr = 12'd2400; u_if.cpu_wr_data = 7'h33;
        #1;
        chk("oor_ready", 32'(u_if.cpu_wr_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("oor_we", 32'(u_if.ram_we), 32'd0);

        // Back-to-back writes
        u_if.cpu_wr_addr = 12'd100; u_if.cpu_wr_data = 7'h11;
        @(posedge clk); @(negedge clk);
        chk("b2b0_we", 32'(u_if.ram_we), 32'd1);
        chk("b2b0_addr", 32'(u_if.ram_addr), 32'd100);
        u_if.cpu_wr_addr = 12'd101; u_if.cpu_wr_data = 7'h22;
        @(posedge clk); @(negedge clk);
        chk("b2b1_we", 32'(u_if.ram_we), 32'd1);
        chk("b2b1_addr", 32'(u_if.ram_addr), 32'd101);
        chk("b2b1_data", 32'(u_if.ram_wdata), 32'h22);
        u_if.cpu_wr_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("b2b_mem100", 32'(mem[100]), 32'h11);
        chk("b2b_mem101", 32'(mem[101]), 32'h22);

        // Written character displayed: 0x5A, cell (1,0) -> bit1 of 0x5A = 1
        v = '{10'd9, 10'd16, 12'd81, 7'h5A, 3'd1, 4'd0, 1'b1};
        run_pixel("wr_rd", v);

        // Cursor blink with solid-0 font
        font_mode = 1'b1;
        u_if.cursor_en = 1'b1; u_if.cursor_addr = 12'd0;
        cur_pixel("cur_ph0_r15", 10'd0, 10'd15, 1'b0);
        vsync_pulses(29);
        cur_pixel("cur_29_r15", 10'd0, 10'd15, 1'b0);
        vsync_pulses(1);
        cur_pixel("cur_30_r14", 10'd0, 10'd14, 1'b1);
        cur_pixel("cur_30_r15", 10'd0, 10'd15, 1'b1);
        cur_pixel("cur_30_x7r15", 10'd7, 10'd15, 1'b1);
        cur_pixel("cur_30_r13", 10'd0, 10'd13, 1'b0);
        cur_pixel("cur_30_r0", 10'd3, 10'd0, 1'b0);
        cur_pixel("cur_30_cell1", 10'd8, 10'd15, 1'b0);
        vsync_pulses(30);
        cur_pixel("cur_60_r15", 10'd0, 10'd15, 1'b0);
        vsync_pulses(30);
        u_if.cursor_en = 1'b0;
        cur_pixel("cur_dis_r15", 10'd0, 10'd15, 1'b0);
        u_if.cursor_en = 1'b1;
        cur_pixel("cur_90_r15", 10'd0, 10'd15, 1'b1);
        u_if.cursor_en = 1'b0;
        font_mode = 1'b0;

        // Sync pass-through: exactly four cycles of delay with active_in low
        ph = 16'b0011_0101_1100_1001;
        pv = 16'b0101_1000_0110_0011;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("hs_dly%0d", k), 32'(u_if.hsync_out), 32'((k >= 4) ? ph[k-4] : 1'b0));
            chk($sformatf("vs_dly%0d", k), 32'(u_if.vsync_out), 32'((k >= 4) ? pv[k-4] : 1'b0));
            chk($sformatf("pix_idle%0d", k), 32'(u_if.pixel_out), 32'd0);
            u_if.hsync_in = (k < 16) ? ph[k] : 1'b0;
            u_if.vsync_in = (k < 16) ? pv[k] : 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
